// File: rtl/screen_scanout.sv
// Raster scanner: walks the screen RAM row-major and serialises each 16-bit word into a 1-pixel/cycle stream.
// Optional frame counter port is built when SCREEN_SCANOUT_FRAME_COUNT_EN is defined.
module screen_scanout #(
    parameter int WORDS_PER_LINE = 32,
    parameter int LINES          = 256,
    parameter int HBLANK         = 16,
    parameter int VBLANK         = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] mem_data,
    output logic [12:0] mem_address,
    output logic        pixel,
    output logic        pixel_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        in_vblank
`ifdef SCREEN_SCANOUT_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int WW        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LW        = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW        = $clog2(BLANK_MAX + 1) + 1;

    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
    localparam logic [BW-1:0] HB_LAST   = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [BW-1:0] VB_LAST   = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_VBLANK = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [3:0]    bit_reg, bit_next;
    logic [WW-1:0] word_reg, word_next;
    logic [LW-1:0] line_reg, line_next;
    logic [BW-1:0] blank_reg, blank_next;
    logic [12:0]   addr_reg, addr_next;
    logic [14:0]   shift_reg, shift_next;
    logic          pixel_reg, pixel_next;
    logic          valid_reg, valid_next;
    logic          ls_reg, ls_next;
    logic          fs_reg, fs_next;
    logic          to_vblank;
    logic          frame_done;

    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        word_next  = word_reg;
        line_next  = line_reg;
        blank_next = blank_reg;
        addr_next  = addr_reg;
        shift_next = shift_reg;
        pixel_next = 1'b0;
        valid_next = 1'b0;
        ls_next    = 1'b0;
        fs_next    = 1'b0;
        to_vblank  = 1'b0;
        frame_done = 1'b0;

        case (state_reg)
            S_IDLE: begin
                bit_next   = '0;
                word_next  = '0;
                line_next  = '0;
                blank_next = '0;
                addr_next  = '0;
                if (enable) state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                valid_next = 1'b1;
                // Word is captured once at b=0; later RAM writes only show next frame.
                if (bit_reg == 4'd0) begin
                    pixel_next = mem_data[0];
                    shift_next = mem_data[15:1];
                    ls_next    = (word_reg == '0);
                    fs_next    = (word_reg == '0) && (line_reg == '0);
                end else begin
                    pixel_next = shift_reg[0];
                    shift_next = {1'b0, shift_reg[14:1]};
                end
                bit_next = bit_reg + 4'd1;
                if (bit_reg == 4'd15) begin
                    if (word_reg == WORD_LAST) begin
                        word_next = '0;
                        if (line_reg == LINE_LAST) begin
                            line_next = '0;
                            addr_next = '0;
                        end else begin
                            line_next = line_reg + LW'(1);
                            addr_next = addr_reg + 13'd1;
                        end
                        if (HBLANK > 0) begin
                            state_next = S_HBLANK;
                            blank_next = '0;
                        end else if (line_reg == LINE_LAST) begin
                            to_vblank = 1'b1;
                        end
                    end else begin
                        word_next = word_reg + WW'(1);
                        addr_next = addr_reg + 13'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (blank_reg == HB_LAST) begin
                    blank_next = '0;
                    if (line_reg != '0) state_next = S_ACTIVE;
                    else                to_vblank  = 1'b1;
                end else begin
                    blank_next = blank_reg + BW'(1);
                end
            end
            default: begin
                if (blank_reg == VB_LAST) begin
                    blank_next = '0;
                    frame_done = 1'b1;
                    state_next = enable ? S_ACTIVE : S_IDLE;
                end else begin
                    blank_next = blank_reg + BW'(1);
                end
            end
        endcase

        // With no vertical blanking the frame ends where VBLANK would have begun.
        if (to_vblank) begin
            blank_next = '0;
            if (VBLANK > 0) begin
                state_next = S_VBLANK;
            end else begin
                frame_done = 1'b1;
                state_next = enable ? S_ACTIVE : S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            bit_reg   <= '0;
            word_reg  <= '0;
            line_reg  <= '0;
            blank_reg <= '0;
            addr_reg  <= '0;
            shift_reg <= '0;
            pixel_reg <= 1'b0;
            valid_reg <= 1'b0;
            ls_reg    <= 1'b0;
            fs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
            word_reg  <= word_next;
            line_reg  <= line_next;
            blank_reg <= blank_next;
            addr_reg  <= addr_next;
            shift_reg <= shift_next;
            pixel_reg <= pixel_next;
            valid_reg <= valid_next;
            ls_reg    <= ls_next;
            fs_reg    <= fs_next;
        end
    end

    assign mem_address = addr_reg;
    assign pixel       = pixel_reg;
    assign pixel_valid = valid_reg;
    assign line_start  = ls_reg;
    assign frame_start = fs_reg;
    assign in_vblank   = (state_reg == S_VBLANK);

`ifdef SCREEN_SCANOUT_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge clock) begin
        if (reset)           frame_count_reg <= '0;
        else if (frame_done) frame_count_reg <= frame_count_reg + 16'd1;
    end

    assign frame_count = frame_count_reg;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
`endif

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: frame-timing reference model computed from cycle position within a frame.
module tb_screen_scanout;

    localparam int W  = 2;
    localparam int L  = 2;
    localparam int H  = 3;
    localparam int V  = 4;
    localparam int P  = 16 * W + H;
    localparam int F  = L * P + V;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] mem_data;
    logic [12:0] mem_address;
    logic        pixel, pixel_valid, line_start, frame_start, in_vblank;
`ifdef SCREEN_SCANOUT_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    logic [15:0] ram [0:8191];
    assign mem_data = ram[mem_address];

    always #5 clock = ~clock;

    screen_scanout #(
        .WORDS_PER_LINE(W),
        .LINES(L),
        .HBLANK(H),
        .VBLANK(V)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mem_data(mem_data),
        .mem_address(mem_address),
        .pixel(pixel),
        .pixel_valid(pixel_valid),
        .line_start(line_start),
        .frame_start(frame_start),
        .in_vblank(in_vblank)
`ifdef SCREEN_SCANOUT_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mdl_on = 1'b0;
    int          mdl_t = 0;
    int          mdl_fc = 0;
    logic [15:0] latched = '0;
    logic [12:0] mdl_addr = '0;

    // Screen address scanned at state position s of a frame (s counts from the frame's first word fetch).
    function automatic logic [12:0] addr_at(input int s);
        int l, c;
        if (s >= L * P) return 13'd0;
        l = s / P;
        c = s % P;
        if (c < 16 * W) return 13'(l * W + c / 16);
        return 13'(((l + 1) % L) * W);
    endfunction

    function automatic bit word_start_at(input int u);
        return (u < L * P) && ((u % P) < 16 * W) && ((u % P) % 16 == 0);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, mdl_t);
        end
    endtask

    task automatic cycle();
        bit   en_e, rst_e;
        int   u, c;
        logic e_pix, e_val, e_ls, e_fs, e_vb;
        logic [12:0] e_ad;
        if (mdl_on && word_start_at((mdl_t + 1) % F)) latched = ram[mdl_addr];
        en_e  = enable;
        rst_e = reset;
        @(posedge clock);
        @(negedge clock);
        if (rst_e) begin
            mdl_on = 1'b0;
            mdl_t  = 0;
            mdl_fc = 0;
        end else if (!mdl_on) begin
            if (en_e) begin
                mdl_on = 1'b1;
                mdl_t  = -1;
            end
        end else begin
            mdl_t++;
            if (mdl_t >= F - 1 && (mdl_t + 1) % F == 0) begin
                mdl_fc++;
                if (!en_e) mdl_on = 1'b0;
            end
        end
        e_pix = 1'b0; e_val = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_vb = 1'b0; e_ad = '0;
        if (mdl_on && mdl_t >= 0) begin
            u = mdl_t % F;
            c = u % P;
            e_val = (u < L * P) && (c < 16 * W);
            e_pix = e_val ? latched[c % 16] : 1'b0;
            e_ls  = e_val && (c == 0);
            e_fs  = (u == 0);
            e_vb  = (u >= L * P - 1) && (u < L * P - 1 + V);
        end
        if (mdl_on) e_ad = addr_at((mdl_t + 1) % F);
        mdl_addr = e_ad;
        chk("pixel", 16'(pixel), 16'(e_pix));
        chk("pixel_valid", 16'(pixel_valid), 16'(e_val));
        chk("line_start", 16'(line_start), 16'(e_ls));
        chk("frame_start", 16'(frame_start), 16'(e_fs));
        chk("in_vblank", 16'(in_vblank), 16'(e_vb));
        chk("mem_address", 16'(mem_address), 16'(e_ad));
`ifdef SCREEN_SCANOUT_FRAME_COUNT_EN
        chk("frame_count", frame_count, 16'(mdl_fc));
`endif
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'h0000;
        ram[0] = 16'h0001;
        ram[1] = 16'h8000;
        ram[2] = 16'($urandom);
        ram[3] = 16'($urandom);

        // Reset held with enable high.
        reset  = 1'b1;
        enable = 1'b1;
        repeat (2) cycle();
        $display("step reset: pixel_valid=%0b mem_address=%0h in_vblank=%0b", pixel_valid, mem_address, in_vblank);

        // First frame with the directed single-bit words, then random screen contents.
        reset = 1'b0;
        repeat (F) cycle();
        $display("step first frame: checks=%0d", n_cmp);
        repeat (2 * F) begin
            if ($urandom_range(0, 3) == 0) ram[$urandom_range(0, 3)] = 16'($urandom);
            cycle();
        end
        $display("step random frames: checks=%0d", n_cmp);

        // Drop enable partway through line 0; the frame must still finish.
        for (int i = 0; i < 2 * F && !(mdl_on && mdl_t >= 0 && mdl_t % F == 10); i++) cycle();
        enable = 1'b0;
        repeat (F + 20) cycle();
        $display("step enable dropped: checks=%0d", n_cmp);

        // Reset in the middle of word 1, then restart.
        enable = 1'b1;
        for (int i = 0; i < 4 * F && !(mdl_on && mdl_t == 22); i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (F + 10) cycle();
        $display("step mid-word reset: checks=%0d", n_cmp);

        // Overwrite word 0 after its fetch; only the following frame shows it.
        reset  = 1'b1;
        ram[0] = 16'h0000;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 2 * F && !(mdl_on && mdl_t == 4); i++) cycle();
        ram[0] = 16'hFFFF;
        repeat (2 * F) cycle();
        $display("step late write: checks=%0d", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
